// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: shared pipeline types, op decode helpers and muldiv sequencer constants
package muldiv_sequencer_pkg;
  typedef logic [63:0] word_t;
  typedef enum logic [6:0] {
    OP_ADD = 7'd0, OP_SUB = 7'd1,
    OP_MUL = 7'd16, OP_MULW, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW
  } decode_op_t;
  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} muldiv_state_t;
  localparam logic [6:0] MD_ITER_64 = 7'd64;
  localparam logic [6:0] MD_ITER_32 = 7'd32;
  function automatic logic is_mop(decode_op_t op);
    return op inside {OP_MUL, OP_MULW, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
                      OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction
  function automatic logic is_wop(decode_op_t op);
    return op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction
  function automatic logic is_sdiv(decode_op_t op);
    return op inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
  endfunction
  function automatic logic is_remop(decode_op_t op);
    return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
  endfunction
  function automatic logic is_mulop(decode_op_t op);
    return op inside {OP_MUL, OP_MULW};
  endfunction
  function automatic word_t sext32(logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction
endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// div_step: one restoring-division step on the {rem,quo} pair
module div_step
  import muldiv_sequencer_pkg::*;
(
  input  word_t rem,
  input  word_t quo,
  input  word_t divisor,
  output word_t rem_next,
  output word_t quo_next
);
  logic [64:0] sh, diff;
  logic ge;
  // rem < divisor on entry, so bit 64 of the 65-bit difference is a clean borrow flag
  assign sh = {rem, quo[63]};
  assign diff = sh - {1'b0, divisor};
  assign ge = !diff[64];
  assign rem_next = ge ? diff[63:0] : sh[63:0];
  assign quo_next = {quo[62:0], ge};
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV64M multiply/divide sequencer with special-case bypass and flush
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  decode_op_t op,
  input  word_t      srca,
  input  word_t      srcb,
  input  logic       flush,
  output logic       busy,
  output logic       done,
  output word_t      result
);
  muldiv_state_t state, state_nx;
  logic [6:0] cnt;
  word_t acc, x, y, acc_nx, x_nx, y_nx, rem_nx, quo_nx;
  word_t a_op, b_op, a_sx, a_abs, b_abs, x_ld, res_special, q, r, v, res_calc;
  logic mul_q, w_q, rem_q, neg_q, neg_r;
  logic w_in, sgn, b_zero, ovf, special, a_neg, b_neg, accept;
  always_comb begin
    w_in = is_wop(op);
    sgn = is_sdiv(op);
    a_op = w_in ? (sgn ? sext32(srca[31:0]) : {32'b0, srca[31:0]}) : srca;
    b_op = w_in ? (sgn ? sext32(srcb[31:0]) : {32'b0, srcb[31:0]}) : srcb;
    a_sx = w_in ? sext32(srca[31:0]) : srca;
    b_zero = b_op == '0;
    ovf = sgn && b_op == '1 && a_op == (w_in ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000);
    special = !is_mulop(op) && (b_zero || ovf);
    a_neg = sgn && a_op[63];
    b_neg = sgn && b_op[63];
    a_abs = a_neg ? -a_op : a_op;
    b_abs = b_neg ? -b_op : b_op;
    // W divides start with the 32-bit dividend in the top half so its MSB is shifted out first
    x_ld = (w_in && !is_mulop(op)) ? {a_abs[31:0], 32'b0} : a_abs;
    res_special = is_remop(op) ? (b_zero ? a_sx : '0) : (b_zero ? '1 : a_sx);
    accept = state == MD_IDLE && !flush && valid && is_mop(op);
  end
  div_step u_div_step (.rem(acc), .quo(x), .divisor(y), .rem_next(rem_nx), .quo_next(quo_nx));
  always_comb begin
    acc_nx = mul_q ? acc + (y[0] ? x : '0) : rem_nx;
    x_nx = mul_q ? x << 1 : quo_nx;
    y_nx = mul_q ? y >> 1 : y;
    q = neg_q ? -x_nx : x_nx;
    r = neg_r ? -acc_nx : acc_nx;
    v = mul_q ? acc_nx : (rem_q ? r : q);
    res_calc = w_q ? sext32(v[31:0]) : v;
  end
  always_ff @(posedge clk)
    if (reset) state <= MD_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = MD_IDLE;
    if (state == MD_IDLE) state_nx = accept ? (special ? MD_DONE : MD_RUN) : MD_IDLE;
    else if (state == MD_RUN) state_nx = flush ? MD_IDLE : (cnt == 7'd1 ? MD_DONE : MD_RUN);
  end
  always_comb begin
    busy = state != MD_IDLE;
    done = state == MD_DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      acc <= '0;
      x <= '0;
      y <= '0;
      {mul_q, w_q, rem_q, neg_q, neg_r} <= '0;
      result <= '0;
    end else begin
      if (accept) begin
        cnt <= w_in ? MD_ITER_32 : MD_ITER_64;
        acc <= '0;
        x <= x_ld;
        y <= b_abs;
        mul_q <= is_mulop(op);
        w_q <= w_in;
        rem_q <= is_remop(op);
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
      end else if (state == MD_RUN) begin
        cnt <= cnt - 7'd1;
        acc <= acc_nx;
        x <= x_nx;
        y <= y_nx;
      end
      if (state_nx == MD_DONE) result <= (state == MD_IDLE) ? res_special : res_calc;
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;
  logic clk = 0, reset = 1, valid = 0, flush = 0;
  decode_op_t op = OP_ADD;
  word_t srca = '0, srcb = '0, result;
  logic busy, done;
  int vectors = 0, errors = 0;
  muldiv_sequencer dut (.clk(clk), .reset(reset), .valid(valid), .op(op), .srca(srca),
                        .srcb(srcb), .flush(flush), .busy(busy), .done(done), .result(result));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input decode_op_t o, input word_t a, input word_t b, input string tag);
    op = o;
    srca = a;
    srcb = b;
    valid = 1;
    step();
    valid = 0;
    check({tag, " busy@T+1"}, busy, 1);
  endtask
  task automatic wait_done(input int n0, input int exp_cyc, input word_t exp_res, input string tag);
    int n = n0;
    while (done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check({tag, " done cycle"}, n, exp_cyc);
    check({tag, " result"}, result, exp_res);
    step();
    check({tag, " done pulse ends"}, {busy, done}, 0);
  endtask
  task automatic run(input decode_op_t o, input word_t a, input word_t b, input int exp_cyc,
                     input word_t exp_res, input string tag);
    start(o, a, b, tag);
    wait_done(1, exp_cyc, exp_res, tag);
  endtask
  initial begin
    repeat (2) step();
    reset = 0;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    op = OP_ADD; valid = 1; srca = 5; srcb = 0;
    step();
    valid = 0;
    check("ADD ignored", busy, 0);
    op = OP_MUL; valid = 1; flush = 1;
    step();
    valid = 0; flush = 0;
    check("flush beats valid in IDLE", busy, 0);
    run(OP_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 65, 64'hFFFF_FFFF_FFFF_FFEB, "MUL");
    run(OP_DIV, -64'sd7, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFD, "DIV");
    run(OP_REM, -64'sd7, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFF, "REM");
    run(OP_DIVU, 64'd100, 64'd7, 65, 64'd14, "DIVU");
    run(OP_DIVU, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, "DIVU by 0");
    run(OP_REMU, 64'd5, 64'd0, 1, 64'd5, "REMU by 0");
    run(OP_DIV, 64'h8000_0000_0000_0000, '1, 1, 64'h8000_0000_0000_0000, "DIV ovf");
    run(OP_MULW, 64'h7FFF_FFFF, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFE, "MULW");
    run(OP_DIVW, 64'h0000_0000_8000_0000, '1, 1, 64'hFFFF_FFFF_8000_0000, "DIVW ovf");
    run(OP_DIVW, -64'sd7, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFD, "DIVW");
    run(OP_REMW, -64'sd7, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFF, "REMW");
    run(OP_DIVUW, 64'hFFFF_FFFF, 64'd2, 33, 64'h0000_0000_7FFF_FFFF, "DIVUW");
    run(OP_REMUW, 64'h0000_0000_8000_0003, 64'hFFFF_FFFF_0000_0000, 1, 64'hFFFF_FFFF_8000_0003, "REMUW by 0");
    start(OP_DIV, 64'd100, 64'd7, "flush DIV");
    repeat (9) step();
    flush = 1;
    step();
    flush = 0;
    check("flush busy@T+11", busy, 0);
    check("flush done@T+11", done, 0);
    check("flush result held", result, 64'hFFFF_FFFF_8000_0003);
    run(OP_MUL, 64'd3, 64'd5, 65, 64'd15, "MUL after flush");
    start(OP_MUL, 64'd6, 64'd7, "ignore MUL");
    op = OP_DIV; srca = 1; srcb = 0; valid = 1;
    repeat (3) step();
    valid = 0;
    wait_done(4, 65, 64'd42, "ignore MUL");
    start(OP_DIV, 64'd100, 64'd7, "reset DIV");
    repeat (19) step();
    reset = 1;
    step();
    reset = 0;
    check("mid-run reset busy", busy, 0);
    check("mid-run reset done", done, 0);
    check("mid-run reset result", result, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
